fpmul_norm_buffer: RTL and testbench

//  Downstream stage of the pipelined FP multiplier. Takes the raw product fields (sign, biased exponent sum, 48-bit mantissa product).

---
 rtl/fpmul_norm_buffer_pkg.sv | 45 ++++
 rtl/fpmul_norm_buffer_fifo.sv | 66 ++++++
 rtl/fpmul_norm_buffer.sv | 180 ++++++++++++++++++
 tb/tb_fpmul_norm_buffer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmul_norm_buffer_pkg.sv
// Shared single-precision definitions for the FP multiplier back end:
// field widths, overflow threshold and the codebase packed result layout.
package fpmul_norm_buffer_pkg;

    localparam int unsigned MAN_W   = 23;  // stored mantissa bits
    localparam int unsigned EXP_W   = 8;   // biased exponent bits
    localparam int unsigned PEXP_W  = 10;  // raw product exponent (two's complement)
    localparam int unsigned PMAN_W  = 48;  // raw mantissa product
    localparam int unsigned IEXP_W  = 12;  // internal signed exponent, headroom for +1 and carry
    localparam int unsigned SIG_W   = MAN_W + 1;

    // Biased exponent at or above this value saturates to infinity.
    localparam logic signed [IEXP_W-1:0] EXP_MAX = 12'sd255;

    // Packed layout {mant @31:9, exp @8:1, sign @0}.
    typedef struct packed {
        logic [MAN_W-1:0] mant;
        logic [EXP_W-1:0] exp;
        logic             sign;
    } fp_word_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic inexact;
    } fp_flags_t;

    typedef struct packed {
        fp_word_t  word;
        fp_flags_t flags;
    } fifo_entry_t;

    localparam int unsigned ENTRY_W = $bits(fifo_entry_t);

    function automatic fp_word_t fp_pack(input logic             sign,
                                         input logic [EXP_W-1:0] exp,
                                         input logic [MAN_W-1:0] mant);
        fp_word_t w;
        w.mant = mant;
        w.exp  = exp;
        w.sign = sign;
        return w;
    endfunction

endpackage

// File: rtl/fpmul_norm_buffer_fifo.sv
// fp_result_fifo: DEPTH x W synchronous FIFO with occupancy count.
// Pointers carry one extra wrap bit; head is read straight from the array.
module fp_result_fifo
    import fpmul_norm_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned W     = ENTRY_W
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          wr_en_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    output logic          rd_valid_o,
    output logic [W-1:0]  rd_data_o,
    output logic [AW:0]   count_o
);

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         empty;
    logic         full;
    logic         do_wr;
    logic         do_rd;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr = wr_en_i & ~full;
    assign do_rd = rd_en_i & ~empty;

    // Pointer advance; reads on an empty FIFO are dropped.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; cleared so the head reads zero out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_valid_o = ~empty;
    assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign count_o    = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fpmul_norm_buffer.sv
// Back end of the pipelined FP multiplier: tracks issued operations through
// the multiplier latency, normalises and rounds (nearest-even) the raw
// product to single precision, and buffers results in a credit-gated FIFO.
module fpmul_norm_buffer
    import fpmul_norm_buffer_pkg::*;
#(
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned AW      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic              prod_sign,
    input  logic [PEXP_W-1:0] prod_exp,
    input  logic [PMAN_W-1:0] prod_man,
    input  logic              prod_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [2:0]        out_flags
);

    logic                     issue_fire;
    logic [MUL_LAT-1:0]       vpipe_q, vpipe_d;
    logic                     arrive;

    logic                     n1_valid_q;
    logic                     n1_sign_q, n1_sign_d;
    logic                     n1_zero_q, n1_zero_d;
    logic signed [IEXP_W-1:0] n1_exp_q, n1_exp_d;
    logic [SIG_W-1:0]         n1_m_q, n1_m_d;
    logic                     n1_g_q, n1_g_d;
    logic                     n1_st_q, n1_st_d;

    logic                     round_up;
    logic [SIG_W:0]           m_sum;
    logic [SIG_W-1:0]         m_rnd;
    logic signed [IEXP_W-1:0] e_rnd;
    logic                     n2_valid_q;
    fp_word_t                 n2_word_q, n2_word_d;
    fp_flags_t                n2_flags_q, n2_flags_d;

    fifo_entry_t              wr_entry;
    fifo_entry_t              head;
    logic [AW:0]              fifo_count;
    logic [7:0]               occupied;

    assign issue_fire = issue_valid & issue_ready;
    assign arrive     = vpipe_q[MUL_LAT-1];

    // Valid pipe mirrors the multiplier latency; its tail qualifies prod_*.
    always_comb begin
        vpipe_d[0] = issue_fire;
        for (int unsigned i = 1; i < MUL_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    end

    // Valid pipe register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vpipe_q <= '0;
        else        vpipe_q <= vpipe_d;
    end

    // N1: one-bit normalisation shift, guard and sticky extraction.
    always_comb begin
        n1_sign_d = prod_sign;
        n1_zero_d = prod_zero;
        if (prod_man[PMAN_W-1]) begin
            n1_m_d   = prod_man[47:24];
            n1_g_d   = prod_man[23];
            n1_st_d  = |prod_man[22:0];
            n1_exp_d = $signed({{(IEXP_W-PEXP_W){prod_exp[PEXP_W-1]}}, prod_exp}) + 12'sd1;
        end else begin
            n1_m_d   = prod_man[46:23];
            n1_g_d   = prod_man[22];
            n1_st_d  = |prod_man[21:0];
            n1_exp_d = $signed({{(IEXP_W-PEXP_W){prod_exp[PEXP_W-1]}}, prod_exp});
        end
    end

    // N1 registers; data only captured for a qualified arrival.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n1_valid_q <= 1'b0;
            n1_sign_q  <= 1'b0;
            n1_zero_q  <= 1'b0;
            n1_exp_q   <= '0;
            n1_m_q     <= '0;
            n1_g_q     <= 1'b0;
            n1_st_q    <= 1'b0;
        end else begin
            n1_valid_q <= arrive;
            if (arrive) begin
                n1_sign_q <= n1_sign_d;
                n1_zero_q <= n1_zero_d;
                n1_exp_q  <= n1_exp_d;
                n1_m_q    <= n1_m_d;
                n1_g_q    <= n1_g_d;
                n1_st_q   <= n1_st_d;
            end
        end
    end

    // N2: round to nearest even, renormalise on carry, then classify.
    always_comb begin
        round_up = n1_g_q & (n1_st_q | n1_m_q[0]);
        m_sum    = {1'b0, n1_m_q} + {{SIG_W{1'b0}}, round_up};
        if (m_sum[SIG_W]) begin
            m_rnd = 24'h800000;
            e_rnd = n1_exp_q + 12'sd1;
        end else begin
            m_rnd = m_sum[SIG_W-1:0];
            e_rnd = n1_exp_q;
        end

        n2_word_d  = fp_pack(n1_sign_q, '0, '0);
        n2_flags_d = '0;
        if (n1_zero_q) begin
            n2_word_d = fp_pack(n1_sign_q, '0, '0);
        end else if (e_rnd >= EXP_MAX) begin
            n2_word_d          = fp_pack(n1_sign_q, '1, '0);
            n2_flags_d.ovf     = 1'b1;
            n2_flags_d.inexact = 1'b1;
        end else if (e_rnd <= 12'sd0) begin
            n2_word_d          = fp_pack(n1_sign_q, '0, '0);
            n2_flags_d.unf     = 1'b1;
            n2_flags_d.inexact = 1'b1;
        end else begin
            n2_word_d          = fp_pack(n1_sign_q, e_rnd[EXP_W-1:0], m_rnd[MAN_W-1:0]);
            n2_flags_d.inexact = n1_g_q | n1_st_q;
        end
    end

    // N2 registers feed the FIFO write port directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n2_valid_q <= 1'b0;
            n2_word_q  <= '0;
            n2_flags_q <= '0;
        end else begin
            n2_valid_q <= n1_valid_q;
            if (n1_valid_q) begin
                n2_word_q  <= n2_word_d;
                n2_flags_q <= n2_flags_d;
            end
        end
    end

    assign wr_entry.word  = n2_word_q;
    assign wr_entry.flags = n2_flags_q;

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_i      (clk),
        .rst_ni     (reset),
        .wr_en_i    (n2_valid_q),
        .wr_data_i  (wr_entry),
        .rd_en_i    (out_ready),
        .rd_valid_o (out_valid),
        .rd_data_o  (head),
        .count_o    (fifo_count)
    );

    // Credits are derived rather than counted: every op in the valid pipe,
    // N1 or N2 is guaranteed a FIFO slot, so issue only while the sum of
    // those plus FIFO occupancy is below DEPTH.
    always_comb begin
        occupied = 8'(fifo_count) + 8'(n1_valid_q) + 8'(n2_valid_q);
        for (int unsigned i = 0; i < MUL_LAT; i++) occupied = occupied + 8'(vpipe_q[i]);
    end

    assign issue_ready = (occupied < 8'(DEPTH));
    assign out_data    = head.word;
    assign out_flags   = head.flags;

endmodule

// File: tb/tb_fpmul_norm_buffer.sv
// Bench for fpmul_norm_buffer: directed vector table, randomized traffic
// against an arithmetic rounding model, backpressure and mid-stream reset.
module tb_fpmul_norm_buffer;

    localparam int MUL_LAT = 5;
    localparam int DEPTH   = 8;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_ready;
    logic        prod_sign;
    logic [9:0]  prod_exp;
    logic [47:0] prod_man;
    logic        prod_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_flags;

    fpmul_norm_buffer #(
        .MUL_LAT (MUL_LAT),
        .DEPTH   (DEPTH),
        .AW      (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .prod_sign   (prod_sign),
        .prod_exp    (prod_exp),
        .prod_man    (prod_man),
        .prod_zero   (prod_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_flags   (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier stand-in: operand fields delayed MUL_LAT cycles, never reset.
    logic        op_s, op_z;
    logic [9:0]  op_e;
    logic [47:0] op_m;
    logic        mp_s [MUL_LAT];
    logic        mp_z [MUL_LAT];
    logic [9:0]  mp_e [MUL_LAT];
    logic [47:0] mp_m [MUL_LAT];

    always @(posedge clk) begin
        for (int i = MUL_LAT - 1; i > 0; i--) begin
            mp_s[i] <= mp_s[i-1];
            mp_z[i] <= mp_z[i-1];
            mp_e[i] <= mp_e[i-1];
            mp_m[i] <= mp_m[i-1];
        end
        mp_s[0] <= op_s;
        mp_z[0] <= op_z;
        mp_e[0] <= op_e;
        mp_m[0] <= op_m;
    end

    assign prod_sign = mp_s[MUL_LAT-1];
    assign prod_zero = mp_z[MUL_LAT-1];
    assign prod_exp  = mp_e[MUL_LAT-1];
    assign prod_man  = mp_m[MUL_LAT-1];

    typedef struct packed {
        logic [31:0] d;
        logic [2:0]  f;
    } res_t;

    typedef struct {
        string       name;
        logic        s;
        logic [9:0]  e;
        logic [47:0] m;
        logic        z;
        logic [31:0] xd;
        logic [2:0]  xf;
    } vec_t;

    res_t sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;
    int   issued = 0;
    int   popped = 0;
    bit   saw_ov;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rounding from plain integer arithmetic on the raw product.
    function automatic res_t ref_model(input logic s, input logic [9:0] e,
                                       input logic [47:0] m, input logic z);
        res_t r;
        longint unsigned man, keep, rem, half;
        int sh, ex;
        bit inex;
        man  = 64'(m);
        sh   = m[47] ? 24 : 23;
        ex   = $signed(e);
        ex   = ex + (m[47] ? 1 : 0);
        keep = man >> sh;
        rem  = man & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        inex = (rem != 0);
        if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        if (keep == (64'd1 << 24)) begin
            keep = keep >> 1;
            ex   = ex + 1;
        end
        if (z) begin
            r.d = {31'd0, s};
            r.f = 3'b000;
        end else if (ex >= 255) begin
            r.d = {23'd0, 8'hFF, s};
            r.f = 3'b101;
        end else if (ex <= 0) begin
            r.d = {31'd0, s};
            r.f = 3'b011;
        end else begin
            r.d = {keep[22:0], ex[7:0], s};
            r.f = {2'b00, inex};
        end
        return r;
    endfunction

    // One clock: drive at negedge, then sample/score 1 time unit later.
    task automatic cycle(input logic iv, input logic s, input logic [9:0] e,
                         input logic [47:0] m, input logic z, input logic ordy,
                         input res_t xtbl, input logic use_tbl);
        res_t r;
        @(negedge clk);
        issue_valid = iv;
        op_s = s; op_e = e; op_m = m; op_z = z;
        out_ready = ordy;
        #1;
        saw_ov = out_valid;
        if (iv && issue_ready) begin
            sb.push_back(use_tbl ? xtbl : ref_model(s, e, m, z));
            issued++;
        end
        if (out_valid && out_ready) begin
            popped++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got %0h expected no result", out_data);
            end else begin
                r = sb.pop_front();
                check("pop_data", 64'(out_data), 64'(r.d));
                check("pop_flags", 64'(out_flags), 64'(r.f));
            end
        end
        check("outstanding_le_depth", 64'((issued - popped) <= DEPTH), 64'd1);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 10'd0, 48'd0, 1'b0, ordy, '0, 1'b0);
    endtask

    task automatic rand_op(output logic s, output logic [9:0] e,
                           output logic [47:0] m, output logic z);
        logic [47:0] a, b;
        int pick, ev;
        a = {24'd0, 1'b1, 23'($urandom)};
        b = {24'd0, 1'b1, 23'($urandom)};
        m = a * b;
        if ($urandom_range(9) == 0) begin
            m[47]   = 1'b0;
            m[46]   = 1'b1;
            m[22:0] = 23'h400000;
        end
        pick = int'($urandom_range(9));
        if (pick == 0)      ev = int'($urandom_range(320, 240));
        else if (pick == 1) ev = int'($urandom_range(14)) - 10;
        else                ev = int'($urandom_range(200, 60));
        e = 10'(ev);
        s = 1'($urandom);
        z = ($urandom_range(19) == 0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            idle(1'b1);
            n++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        idle(1'b1);
        check("drain_out_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic        s, z;
        logic [9:0]  e;
        logic [47:0] m;
        res_t        x;
        int          lat, base, any_ov, any_nr;

        reset = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
        op_s = 1'b0; op_e = '0; op_m = '0; op_z = 1'b0;

        tbl.push_back('{"mul_1p5",     1'b0, 10'd127,  48'h9000_0000_0000, 1'b0, 32'h2000_0100, 3'b000});
        tbl.push_back('{"round_carry", 1'b0, 10'd127,  48'h7FFF_FFC0_0000, 1'b0, 32'h0000_0100, 3'b001});
        tbl.push_back('{"overflow",    1'b0, 10'd300,  48'h4000_0000_0000, 1'b0, 32'h0000_01FE, 3'b101});
        tbl.push_back('{"underflow",   1'b1, 10'h3FB,  48'h4000_0000_0000, 1'b0, 32'h0000_0001, 3'b011});
        tbl.push_back('{"zero",        1'b1, 10'd300,  48'hFFFF_FFFF_FFFF, 1'b1, 32'h0000_0001, 3'b000});
        tbl.push_back('{"tie_down",    1'b0, 10'd127,  48'h4000_0040_0000, 1'b0, 32'h0000_00FE, 3'b001});
        tbl.push_back('{"tie_up",      1'b0, 10'd127,  48'h4000_00C0_0000, 1'b0, 32'h0000_04FE, 3'b001});
        tbl.push_back('{"sticky_up",   1'b0, 10'd127,  48'h4000_0060_0000, 1'b0, 32'h0000_02FE, 3'b001});
        tbl.push_back('{"exp_eq_0",    1'b0, 10'h3FF,  48'h8000_0000_0000, 1'b0, 32'h0000_0000, 3'b011});
        tbl.push_back('{"exp_eq_1",    1'b0, 10'd0,    48'h8000_0000_0000, 1'b0, 32'h0000_0002, 3'b000});
        tbl.push_back('{"exp_eq_254",  1'b0, 10'd253,  48'h8000_0000_0000, 1'b0, 32'h0000_01FC, 3'b000});
        tbl.push_back('{"exp_eq_255",  1'b0, 10'd254,  48'h8000_0000_0000, 1'b0, 32'h0000_01FE, 3'b101});
        tbl.push_back('{"carry_ovf",   1'b1, 10'd254,  48'h7FFF_FFC0_0000, 1'b0, 32'h0000_01FF, 3'b101});

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_out_valid",   64'(out_valid),   64'd0);
        check("rst_out_data",    64'(out_data),    64'd0);
        check("rst_out_flags",   64'(out_flags),   64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors, one at a time from an empty FIFO, with latency.
        foreach (tbl[i]) begin
            x.d = tbl[i].xd;
            x.f = tbl[i].xf;
            cycle(1'b1, tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].z, 1'b1, x, 1'b1);
            lat = 0;
            saw_ov = 1'b0;
            while (!saw_ov && lat < 40) begin
                idle(1'b1);
                lat++;
            end
            check({"latency_", tbl[i].name}, 64'(lat), 64'(MUL_LAT + 3));
            check({"drained_", tbl[i].name}, 64'(sb.size()), 64'd0);
        end
        idle(1'b1);

        // Backpressure: consumer stalled, issue held high.
        base = issued;
        for (int k = 0; k < 20; k++) begin
            rand_op(s, e, m, z);
            cycle(1'b1, s, e, m, z, 1'b0, '0, 1'b0);
        end
        check("bp_accepted", 64'(issued - base), 64'(DEPTH));
        check("bp_issue_ready_low", 64'(issue_ready), 64'd0);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 40; k++) begin
            rand_op(s, e, m, z);
            cycle(1'b1, s, e, m, z, 1'b1, '0, 1'b0);
        end
        check("bp_resumed", 64'((issued - base) > DEPTH + 20), 64'd1);
        drain();

        // Randomized traffic with random stalls.
        for (int k = 0; k < 600; k++) begin
            rand_op(s, e, m, z);
            cycle(1'($urandom_range(99) < 60), s, e, m, z,
                  1'($urandom_range(99) < 70), '0, 1'b0);
        end
        drain();

        // Reset with three operations inside the multiplier.
        for (int k = 0; k < 3; k++) begin
            rand_op(s, e, m, z);
            cycle(1'b1, s, e, m, z, 1'b1, '0, 1'b0);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        issued = 0;
        popped = 0;
        any_ov = 0;
        any_nr = 0;
        for (int k = 0; k < 15; k++) begin
            idle(1'b1);
            if (out_valid)    any_ov++;
            if (!issue_ready) any_nr++;
        end
        check("mid_rst_out_valid",   64'(any_ov),    64'd0);
        check("mid_rst_issue_ready", 64'(any_nr),    64'd0);
        check("mid_rst_out_data",    64'(out_data),  64'd0);

        // Normal operation resumes after the reset.
        rand_op(s, e, m, z);
        cycle(1'b1, s, e, m, z, 1'b1, '0, 1'b0);
        drain();
        check("post_rst_popped", 64'(popped), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
